mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store access controller between the MEM pipeline stage and a
// byte-addressed data memory. Aligned accesses use a single memory cycle.
// Misaligned loads read one or two aligned doublewords and extract the
// requested bytes. Misaligned stores are split into single-byte writes.
// Illegal requests complete with err set and never touch memory.
//
// state   | meaning
// IDLE    | no request outstanding
// ACC_A   | first (or only) memory access
// ACC_B   | second doubleword read of a split misaligned load
// BYTE_WR | one byte of a misaligned store per cycle
// RESP    | done pulse; a new request may be accepted
module mem_access_ctrl #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [3:0]  req_size,
    input  logic        req_sext,
    input  logic [63:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] rd_data,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [3:0]  mem_xfer_size,
    input  logic [63:0] mem_read_data
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACC_A   = 3'd1,
        ACC_B   = 3'd2,
        BYTE_WR = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

    state_t      state;
    state_t      state_nxt;

    logic [63:0] q_addr;
    logic [63:0] q_wdata;
    logic [3:0]  q_size;
    logic        q_write;
    logic        q_sext;
    logic        q_aligned;
    logic        q_split;
    logic        q_err;
    logic [63:0] buf_a;
    logic [63:0] rd_q;
    logic [63:0] byte_addr;
    logic [63:0] byte_data;
    logic [3:0]  bytes_left;

    logic        accept;
    logic        size_ok;
    logic        range_ok;
    logic        req_legal;
    logic        req_aligned;
    logic        req_split;
    logic [2:0]  load_off;

    // Shift the raw bytes down to the requested address, then zero or
    // sign extend above the transfer size.
    function automatic logic [63:0] shape_load(input logic [127:0] raw,
                                               input logic [2:0]   off,
                                               input logic [3:0]   size,
                                               input logic         sext);
        logic [63:0] v;
        v = 64'(raw >> {off, 3'b000});
        case (size)
            4'd1:    v = {{56{sext & v[7]}},  v[7:0]};
            4'd2:    v = {{48{sext & v[15]}}, v[15:0]};
            4'd4:    v = {{32{sext & v[31]}}, v[31:0]};
            default: v = v;
        endcase
        return v;
    endfunction

    assign busy     = (state == ACC_A) || (state == ACC_B) || (state == BYTE_WR);
    assign accept   = req_valid && !busy;
    assign done     = (state == RESP);
    assign err      = (state == RESP) && q_err;
    assign rd_data  = rd_q;
    assign load_off = q_aligned ? 3'd0 : q_addr[2:0];

    // Request classification; the range test is written as a compare
    // against MEM_BYTES - size so a huge address cannot wrap around.
    always_comb begin
        size_ok     = (req_size == 4'd1) || (req_size == 4'd2) ||
                      (req_size == 4'd4) || (req_size == 4'd8);
        range_ok    = size_ok && (req_addr <= (MEM_LIMIT - {60'd0, req_size}));
        req_legal   = size_ok && range_ok;
        req_aligned = (req_addr[2:0] & (req_size[2:0] - 3'd1)) == 3'd0;
        req_split   = ({1'b0, req_addr[2:0]} + req_size) > 4'd8;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory port drive.
    always_comb begin
        state_nxt        = state;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = 64'd0;
        mem_write_data   = 64'd0;
        mem_xfer_size    = 4'd8;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (!req_legal) begin
                        state_nxt = RESP;
                    end else if (req_write && !req_aligned) begin
                        state_nxt = BYTE_WR;
                    end else begin
                        state_nxt = ACC_A;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACC_A: begin
                state_nxt = q_split ? ACC_B : RESP;
                if (q_write) begin
                    mem_write_enable = 1'b1;
                    mem_address      = q_addr;
                    mem_xfer_size    = q_size;
                    mem_write_data   = q_wdata;
                end else begin
                    mem_read_enable = 1'b1;
                    mem_address     = q_aligned ? q_addr : {q_addr[63:3], 3'b000};
                    mem_xfer_size   = q_aligned ? q_size : 4'd8;
                end
            end
            ACC_B: begin
                state_nxt       = RESP;
                mem_read_enable = 1'b1;
                mem_address     = {q_addr[63:3], 3'b000} + 64'd8;
                mem_xfer_size   = 4'd8;
            end
            BYTE_WR: begin
                state_nxt        = (bytes_left == 4'd1) ? RESP : BYTE_WR;
                mem_write_enable = 1'b1;
                mem_address      = byte_addr;
                mem_xfer_size    = 4'd1;
                mem_write_data   = {56'd0, byte_data[7:0]};
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, read capture and byte-store sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_addr     <= 64'd0;
            q_wdata    <= 64'd0;
            q_size     <= 4'd0;
            q_write    <= 1'b0;
            q_sext     <= 1'b0;
            q_aligned  <= 1'b0;
            q_split    <= 1'b0;
            q_err      <= 1'b0;
            buf_a      <= 64'd0;
            rd_q       <= 64'd0;
            byte_addr  <= 64'd0;
            byte_data  <= 64'd0;
            bytes_left <= 4'd0;
        end else begin
            if (accept) begin
                q_addr     <= req_addr;
                q_wdata    <= req_wdata;
                q_size     <= req_size;
                q_write    <= req_write;
                q_sext     <= req_sext;
                q_aligned  <= req_aligned;
                q_split    <= req_split && !req_aligned && !req_write;
                q_err      <= !req_legal;
                byte_addr  <= req_addr;
                byte_data  <= req_wdata;
                bytes_left <= req_size;
                if (!req_legal) begin
                    rd_q <= 64'd0;
                end
            end
            case (state)
                ACC_A: begin
                    if (!q_write) begin
                        if (q_split) begin
                            buf_a <= mem_read_data;
                        end else begin
                            rd_q <= shape_load({64'd0, mem_read_data}, load_off,
                                               q_size, q_sext);
                        end
                    end
                end
                ACC_B: begin
                    rd_q <= shape_load({mem_read_data, buf_a}, load_off, q_size, q_sext);
                end
                BYTE_WR: begin
                    byte_addr  <= byte_addr + 64'd1;
                    byte_data  <= {8'd0, byte_data[63:8]};
                    bytes_left <= bytes_left - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
